// File: rtl/rca_seq_pkg.sv
// ---------------------------------------------------------------------------
// rca_seq_pkg
// Shared definitions for the nibble-serial ripple-carry add sequencer.
//   NIB_W      : width of one adder-stage slice (4 bits)
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   nib_count  : number of nibbles in a word of the given width
// ---------------------------------------------------------------------------
package rca_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/rca_nibble_slice.sv
// ---------------------------------------------------------------------------
// rca_nibble_slice
// Pure combinational helper for the sequencer: selects the current operand
// nibbles for the external adder stage and builds the next value of the
// result register with the adder's sum written into the current nibble.
// Ports:
//   a_reg, b_reg  in  WIDTH   latched operands
//   sum_reg       in  WIDTH   partial result assembled so far
//   idx           in  IDX_W   nibble currently being processed
//   nib_s         in  4       sum returned by the adder stage
//   a_nib, b_nib  out 4       operand nibbles selected by idx
//   sum_next      out WIDTH   sum_reg with nibble idx replaced by nib_s
// ---------------------------------------------------------------------------
module rca_nibble_slice
   import rca_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IDX_W = 2
) (
   input  logic [WIDTH-1:0] a_reg,
   input  logic [WIDTH-1:0] b_reg,
   input  logic [WIDTH-1:0] sum_reg,
   input  logic [IDX_W-1:0] idx,
   input  logic [NIB_W-1:0] nib_s,
   output logic [NIB_W-1:0] a_nib,
   output logic [NIB_W-1:0] b_nib,
   output logic [WIDTH-1:0] sum_next
);

   // Operand selection: idx never exceeds the last nibble, so the indexed
   // part-select always stays inside the word.
   always_comb begin
      a_nib = a_reg[idx*NIB_W +: NIB_W];
      b_nib = b_reg[idx*NIB_W +: NIB_W];
   end

   // Result merge: every other nibble keeps its previously captured value.
   always_comb begin
      sum_next = sum_reg;
      sum_next[idx*NIB_W +: NIB_W] = nib_s;
   end

endmodule

// File: rtl/rca_nibble_seq.sv
// ---------------------------------------------------------------------------
// rca_nibble_seq
// Performs WIDTH-bit additions one nibble per cycle through an external
// 4-bit ripple-carry adder stage. Operands are accepted with in_valid /
// in_ready, sliced LSB-first onto add_a/add_b/add_ci, the stage's add_s /
// add_co are captured every RUN cycle, and the assembled result is held on
// out_sum/out_co behind out_valid / out_ready.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid, in_ready   operand handshake
//   in_a, in_b, in_ci    operands and wide carry-in
//   add_a, add_b, add_ci drive to the adder stage (zero outside RUN)
//   add_s, add_co        combinational response of the adder stage
//   out_valid, out_ready result handshake
//   out_sum, out_co      result (modulo 2^WIDTH) and final carry-out
//   out_ovf              signed overflow (only with RCA_NIBBLE_SEQ_OVF_EN)
// Optional feature macro: RCA_NIBBLE_SEQ_OVF_EN
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module rca_nibble_seq
   import rca_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_ci,
   input  logic [3:0]       add_s,
   input  logic             add_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_co
`ifdef RCA_NIBBLE_SEQ_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int NIBBLES = nib_count(WIDTH);
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;

   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [WIDTH-1:0] sum_next;

   rca_nibble_slice #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_slice (
      .a_reg    (a_reg),
      .b_reg    (b_reg),
      .sum_reg  (sum_reg),
      .idx      (idx),
      .nib_s    (add_s),
      .a_nib    (a_nib),
      .b_nib    (b_nib),
      .sum_next (sum_next)
   );

   // The adder stage is combinational, so its inputs come straight from
   // registered state; outside RUN they are held at zero to keep it quiet.
   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_ci = 1'b0;
      if (state == RUN) begin
         add_a  = a_nib;
         add_b  = b_nib;
         add_ci = carry;
      end
   end

   // Main sequencer. The result outputs are loaded on the same edge that
   // captures the last nibble (using sum_next, not sum_reg), so out_valid
   // rises exactly NIBBLES edges after acceptance and out_* then hold
   // untouched until the consumer takes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_co    <= 1'b0;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  carry    <= in_ci;
                  idx      <= '0;
                  sum_reg  <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum_reg <= sum_next;
               carry   <= add_co;
               if (idx == LAST_IDX) begin
                  out_valid <= 1'b1;
                  out_sum   <= sum_next;
                  out_co    <= add_co;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
                  out_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_rca_nibble_seq
// Self-checking bench for rca_nibble_seq (WIDTH=16). Supplies a behavioural
// 4-bit adder stage, runs directed and random additions and compares the
// DUT against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rca_nibble_seq;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_ci;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_ci;
   logic [3:0]   add_s;
   logic         add_co;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_co;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
   logic         out_ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   rca_nibble_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ci     (in_ci),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_ci    (add_ci),
      .add_s     (add_s),
      .add_co    (add_co),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_co    (out_co)
`ifdef RCA_NIBBLE_SEQ_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   // External 4-bit adder stage the sequencer talks to.
   logic [4:0] stage;
   assign stage  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
   assign add_s  = stage[3:0];
   assign add_co = stage[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Carry entering nibble k of a + b + ci, from the low 4*k bits alone.
   function automatic logic nibCarry(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci, input int k);
      longint unsigned m;
      longint unsigned s;
      m = (64'd1 << (4 * k)) - 64'd1;
      s = (longint'(a) & m) + (longint'(b) & m) + longint'(ci);
      return s[4*k];
   endfunction

   // One full operation: offer operands, follow every RUN cycle, check the
   // result, hold backpressure for 'hold' cycles with ignored requests, then
   // complete the output handshake.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input int hold);
      logic [W:0] full;
      int n;
      int j;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_idle", in_ready, 1);
      checkOutput("add_quiet_idle", {add_a, add_b, add_ci}, 0);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_ci    = ci;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_ci    = 1'($urandom);
      j = 0;
      while (!out_valid && j < 3 * NIB) begin
         if (j < NIB) begin
            checkOutput($sformatf("add_a_nib%0d", j), add_a, a[4*j +: 4]);
            checkOutput($sformatf("add_b_nib%0d", j), add_b, b[4*j +: 4]);
            checkOutput($sformatf("add_ci_nib%0d", j), add_ci, nibCarry(a, b, ci, j));
            checkOutput("in_ready_run", in_ready, 0);
         end
         @(negedge clk);
         j++;
      end
      checkOutput("latency", j, NIB);
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_sum", out_sum, full[W-1:0]);
      checkOutput("out_co", out_co, full[W]);
`ifdef RCA_NIBBLE_SEQ_OVF_EN
      checkOutput("out_ovf", out_ovf, (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]));
`endif
      checkOutput("add_quiet_done", {add_a, add_b, add_ci}, 0);
      checkOutput("in_ready_done", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_valid  = 1'b1;
         in_a      = W'($urandom);
         in_b      = W'($urandom);
         out_ready = 1'b0;
         @(negedge clk);
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_sum", out_sum, full[W-1:0]);
         checkOutput("hold_co", out_co, full[W]);
         checkOutput("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("after_hs_valid", out_valid, 0);
      checkOutput("after_hs_in_ready", in_ready, 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_ci     = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_sum", out_sum, 0);
      checkOutput("rst_out_co", out_co, 0);
      checkOutput("rst_add", {add_a, add_b, add_ci}, 0);

      $display("[TB] directed operations");
      applyStimulus(16'h1234, 16'h0FFF, 1'b0, 0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1);
      applyStimulus(16'hABCD, 16'h1111, 1'b0, 10);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 0);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 2);

      // Reset during the second RUN cycle must discard the operation.
      $display("[TB] reset during RUN");
      in_valid = 1'b1;
      in_a     = 16'h5A5A;
      in_b     = 16'hA5A5;
      in_ci    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_in_ready", in_ready, 1);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_sum", out_sum, 0);
      checkOutput("midrst_out_co", out_co, 0);
      checkOutput("midrst_add", {add_a, add_b, add_ci}, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("midrst_no_valid", out_valid, 0);
      end
      out_ready = 1'b0;
      applyStimulus(16'h0001, 16'h0001, 1'b0, 0);

      $display("[TB] random operations");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
